qpsk_tx_shaper: RTL
===================

# qpsk_tx_shaper

Transmit-side pulse-shaping filter for one QPSK rail. Accepts one bit per symbol through a valid/ready handshake, upsamples by UPSAMPLE and filters with a polyphase root-raised-cosine FIR. Emits one signed DATA_NBITS sample per enabled clock to the channel model, whose output feeds the matching `rx` decision block. One instance per I/Q rail.

## Interface
- UPSAMPLE, 4: samples per symbol; power of two, ≥2.
- NCOEF, 24: FIR taps; multiple of UPSAMPLE. NTAPS = NCOEF/UPSAMPLE taps per phase.
- COEF_NBITS, 8: coefficient width, signed.
- COEF_FBITS, 7: coefficient fractional bits.
- COEF, all zeros: packed NCOEF*COEF_NBITS vector; h[0] in the MSBs.
- DATA_NBITS, 8: output sample width, signed.
- DATA_FBITS, 7: output fractional bits; must be ≤ COEF_FBITS.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  sample-rate strobe; the block advances only on cycles where it is high.
- tx_in  in  1  symbol bit: 1 → +1, 0 → −1.
- tx_valid  in  1  tx_in holds a symbol.
- tx_ready  out  1  combinational: enable && phase==0; symbol consumed when tx_valid && tx_ready.
- tx_out  out  DATA_NBITS  shaped sample, registered, S(DATA_NBITS,DATA_FBITS).

## Operation
- State:
  - phase counter, $clog2(UPSAMPLE) bits;
  - symbol line of NTAPS entries, each {present, bit}; entry 0 is newest;
  - tx_out register.
- Reset (rst high at clk edge):
  - phase=0; all entries present=0; tx_out=0;
  - coefficients loaded from COEF; h[i] = COEF[NCOEF*COEF_NBITS−1−i*COEF_NBITS -: COEF_NBITS].
- Enabled cycle, current phase p:
  - p==0: the line shifts by one (entry k → k+1, oldest dropped). Entry 0 becomes {tx_valid, tx_in}. A missing symbol (tx_valid=0) inserts a zero symbol, which is the idle/flush mechanism; the block never stalls.
  - Line' is the line after any shift.
  - sum = Σ_k c_k·h[k*UPSAMPLE+p] over k=0..NTAPS−1, where c_k = +1 (present, bit 1), −1 (present, bit 0), or 0 (not present).
  - tx_out ← conv(sum).
  - phase ← p+1, wrapping UPSAMPLE−1 → 0.
- Disabled cycle: phase, line and tx_out hold. tx_ready=0.
- Arithmetic:
  - sum is full-precision signed, width COEF_NBITS+$clog2(NTAPS)+1, with COEF_FBITS fractional bits.
  - conv drops COEF_FBITS−DATA_FBITS LSBs by truncation (floor), then narrows to DATA_NBITS per the configuration below.
- tx_valid high while tx_ready is low is a held request and is not consumed.
- tx_in and tx_valid are ignored at p≠0.

## Timing
- A symbol accepted at an edge with phase 0 produces its h[0] term in tx_out from the next cycle.
- Its full impulse response appears over the next NCOEF enabled cycles, h[0]..h[NCOEF−1], in order.
- tx_ready is high exactly one of every UPSAMPLE enabled cycles, on the first enabled cycle after reset.
- enable gaps stretch the schedule without changing the sample sequence.
- Reset mid-operation takes priority over enable: the next cycle has tx_out=0 and phase 0, and in-flight symbols are discarded.

## Configuration
- TX_SATURATE_EN defined: narrowing clamps to [−2^(DATA_NBITS−1), 2^(DATA_NBITS−1)−1].
- TX_SATURATE_EN undefined: narrowing keeps the low DATA_NBITS bits (two's-complement wrap); no clamp logic is built.

## Test plan
All scenarios except saturation use UPSAMPLE=4, NCOEF=8, h = 64,32,16,8,4,2,1,0, DATA_FBITS=COEF_FBITS=7, and enable held high unless noted.
- Reset release → tx_out=0, tx_ready=1 on the first cycle, then 0,0,0,1 repeating.
- Single bit 1 at phase 0, then tx_valid=0 → tx_out = 64,32,16,8,4,2,1,0, then 0 constant.
- Single bit 0 → tx_out = −64,−32,−16,−8,−4,−2,−1,0. Bits 1 then 0 on consecutive symbols → the fifth sample is 4−64 = −60.
- Saturation: h all 127, two consecutive 1s, fifth sample sum 254 → 127 with TX_SATURATE_EN, −2 without.
- Hold: drop enable for 3 cycles at phase 2 → tx_out and phase frozen, tx_ready=0; the sequence resumes unchanged.
- Reset at phase 2 mid-impulse → next cycle tx_out=0; without new symbols the output stays 0 and tx_ready is asserted on the first enabled cycle.

Source files
------------

// File: rtl/qpsk_tx_shaper.sv
// Polyphase root-raised-cosine transmit shaper for one QPSK rail (1 bit/symbol in, UPSAMPLE samples out).
// Optional output clamping is built when TX_SATURATE_EN is defined; otherwise the output wraps.
module qpsk_tx_shaper #(
  parameter int unsigned UPSAMPLE   = 4,
  parameter int unsigned NCOEF      = 24,
  parameter int unsigned COEF_NBITS = 8,
  parameter int unsigned COEF_FBITS = 7,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0,
  parameter int unsigned DATA_NBITS = 8,
  parameter int unsigned DATA_FBITS = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         tx_in,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic signed [DATA_NBITS-1:0] tx_out
);

  localparam int unsigned NTAPS = NCOEF / UPSAMPLE;
  localparam int unsigned PW    = $clog2(UPSAMPLE);
  localparam int unsigned SW    = COEF_NBITS + $clog2(NTAPS) + 1;
  localparam int unsigned SHIFT = COEF_FBITS - DATA_FBITS;

  logic [PW-1:0]    phase;
  logic [NTAPS-1:0] line_present;
  logic [NTAPS-1:0] line_bit;

  logic [NTAPS-1:0]             line_present_n;
  logic [NTAPS-1:0]             line_bit_n;
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         shifted;
  logic signed [DATA_NBITS-1:0] sample;

  // Coefficients regrouped by phase: h_ph[p][k] = h[k*UPSAMPLE+p]
  logic signed [COEF_NBITS-1:0] h_ph [UPSAMPLE][NTAPS];

  for (genvar p = 0; p < UPSAMPLE; p++) begin : g_phase
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
      assign h_ph[p][k] = COEF[NCOEF*COEF_NBITS-1-(k*UPSAMPLE+p)*COEF_NBITS -: COEF_NBITS];
    end
  end

  assign tx_ready = enable && (phase == '0);

  // Line update, phase dot product and output narrowing
  always_comb begin
    line_present_n = line_present;
    line_bit_n     = line_bit;
    if (phase == '0) begin
      line_present_n = NTAPS'({line_present, tx_valid});
      line_bit_n     = NTAPS'({line_bit, tx_in});
    end

    sum = '0;
    for (int k = 0; k < int'(NTAPS); k++) begin
      if (line_present_n[k]) begin
        if (line_bit_n[k]) sum = sum + SW'(h_ph[phase][k]);
        else               sum = sum - SW'(h_ph[phase][k]);
      end
    end

    shifted = sum >>> SHIFT;
`ifdef TX_SATURATE_EN
    if (shifted > SW'(2**(DATA_NBITS-1)-1)) begin
      sample = DATA_NBITS'(2**(DATA_NBITS-1)-1);
    end else if (shifted < -(SW'(2**(DATA_NBITS-1)))) begin
      sample = DATA_NBITS'(2**(DATA_NBITS-1));
    end else begin
      sample = DATA_NBITS'(shifted);
    end
`else
    sample = DATA_NBITS'(shifted);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      line_present <= '0;
      line_bit     <= '0;
      tx_out       <= '0;
    end else if (enable) begin
      phase        <= phase + PW'(1);
      line_present <= line_present_n;
      line_bit     <= line_bit_n;
      tx_out       <= sample;
    end
  end

endmodule
